// File: rtl/lbist_controller.sv
// ----------------------------------------------------------------------------
// lbist_controller
// Sequences one logic-BIST run: reseeds the TPG and clears the MISR, applies
// N_PATTERNS LFSR patterns, flushes the capture pipeline for LATENCY cycles,
// then compares the MISR signature against GOLDEN_SIG and holds the verdict.
//
// Ports
//   clk          in   clock, all state changes on the rising edge
//   rst          in   synchronous active-high reset
//   start        in   level request to begin a run (honoured in IDLE/DONE)
//   abort        in   (LBIST_ABORT_EN only) cancel an active run
//   misr_sig     in   current MISR signature
//   tpg_en       out  LFSR shift enable
//   tpg_rst_n    out  active-low LFSR seed reload
//   misr_en      out  MISR compaction enable
//   misr_rst_n   out  active-low MISR clear
//   test_mode    out  routes TPG patterns into the CUT
//   busy         out  run in progress
//   done         out  run complete, go/nogo valid
//   go / nogo    out  signature matched / mismatched
//
// Optional feature macro: LBIST_ABORT_EN (adds the abort input).
// All outputs come straight from flops; nothing combinational reaches a port.
// ----------------------------------------------------------------------------
module lbist_controller #(
    parameter int unsigned      N_PATTERNS = 1000,
    parameter int unsigned      CNT_W      = 20,
    parameter int unsigned      LATENCY    = 2,
    parameter int unsigned      SIG_W      = 24,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef LBIST_ABORT_EN
    input  logic             abort,
`endif
    input  logic [SIG_W-1:0] misr_sig,
    output logic             tpg_en,
    output logic             tpg_rst_n,
    output logic             misr_en,
    output logic             misr_rst_n,
    output logic             test_mode,
    output logic             busy,
    output logic             done,
    output logic             go,
    output logic             nogo
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_FLUSH,
        S_COMPARE,
        S_DONE
    } state_e;

    typedef struct packed {
        logic tpg_en;
        logic tpg_rst_n;
        logic misr_en;
        logic misr_rst_n;
        logic test_mode;
        logic busy;
        logic done;
    } ctl_t;

    // Terminal counts; FLUSH_LAST is unused when LATENCY is 0
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(N_PATTERNS - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'((LATENCY == 0) ? 0 : LATENCY - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctl_t             ctl_q;
    logic             go_q, nogo_q;
    logic             sig_match;

    assign sig_match = (misr_sig == GOLDEN_SIG);

    // Control-output pattern for the state being entered
    function automatic ctl_t decode(input state_e s);
        ctl_t c;
        c            = '0;
        c.tpg_rst_n  = 1'b1;
        c.misr_rst_n = 1'b1;
        case (s)
            S_INIT: begin
                c.tpg_rst_n  = 1'b0;
                c.misr_rst_n = 1'b0;
                c.test_mode  = 1'b1;
                c.busy       = 1'b1;
            end
            S_RUN: begin
                c.tpg_en    = 1'b1;
                c.misr_en   = 1'b1;
                c.test_mode = 1'b1;
                c.busy      = 1'b1;
            end
            S_FLUSH: begin
                c.misr_en   = 1'b1;
                c.test_mode = 1'b1;
                c.busy      = 1'b1;
            end
            S_COMPARE: begin
                c.test_mode = 1'b1;
                c.busy      = 1'b1;
            end
            S_DONE:  c.done = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    // Next state and pattern/flush counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) state_d = S_INIT;
            end
            S_INIT: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (cnt_q == RUN_LAST) begin
                    cnt_d   = '0;
                    state_d = (LATENCY != 0) ? S_FLUSH : S_COMPARE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    cnt_d   = '0;
                    state_d = S_COMPARE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_COMPARE: state_d = S_DONE;
            S_DONE: begin
                if (start) state_d = S_INIT;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
`ifdef LBIST_ABORT_EN
        // Abort only cancels an active run; IDLE and DONE ignore it
        if (abort && (state_q inside {S_INIT, S_RUN, S_FLUSH, S_COMPARE})) begin
            cnt_d   = '0;
            state_d = S_IDLE;
        end
`endif
    end

    // State, counter and registered outputs; verdict captured on COMPARE->DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ctl_q   <= decode(S_IDLE);
            go_q    <= 1'b0;
            nogo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctl_q   <= decode(state_d);
            if (state_d != S_DONE) begin
                go_q   <= 1'b0;
                nogo_q <= 1'b0;
            end else if (state_q == S_COMPARE) begin
                go_q   <= sig_match;
                nogo_q <= ~sig_match;
            end
        end
    end

    assign tpg_en     = ctl_q.tpg_en;
    assign tpg_rst_n  = ctl_q.tpg_rst_n;
    assign misr_en    = ctl_q.misr_en;
    assign misr_rst_n = ctl_q.misr_rst_n;
    assign test_mode  = ctl_q.test_mode;
    assign busy       = ctl_q.busy;
    assign done       = ctl_q.done;
    assign go         = go_q;
    assign nogo       = nogo_q;

endmodule
